// File: rtl/centroid_divider.sv
// Multi-channel restoring divider: each enabled channel computes floor(dividend/divisor)
// over NUM_W RUN cycles; divide-by-zero channels flag dz and keep their previous quotient.

module centroid_divider_lane #(
    parameter int NUM_W = 20,
    parameter int DEN_W = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic             last,
    input  logic             en_in,
    input  logic [NUM_W-1:0] dvd_in,
    input  logic [DEN_W-1:0] div_in,
    output logic [NUM_W-1:0] q,
    output logic             dz
);
    logic             en_q, en_d;
    logic [NUM_W-1:0] dvd_q, dvd_d;
    logic [DEN_W-1:0] div_q, div_d;
    logic [DEN_W:0]   rem_q, rem_d;
    logic [NUM_W-1:0] quo_q, quo_d;
    logic [NUM_W-1:0] q_q, q_d;
    logic             dz_q, dz_d;

    logic [DEN_W:0]   shifted;
    logic             ge;
    logic [DEN_W:0]   rem_nxt;
    logic [NUM_W-1:0] quo_nxt;

    always_comb begin
        shifted = {rem_q[DEN_W-1:0], dvd_q[NUM_W-1]};
        // A set top bit can only appear with a zero divisor, whose result is discarded.
        ge      = rem_q[DEN_W] || (shifted >= {1'b0, div_q});
        rem_nxt = ge ? (shifted - {1'b0, div_q}) : shifted;
        quo_nxt = (quo_q << 1) | {{(NUM_W-1){1'b0}}, ge};

        en_d  = en_q;
        dvd_d = dvd_q;
        div_d = div_q;
        rem_d = rem_q;
        quo_d = quo_q;
        q_d   = q_q;
        dz_d  = dz_q;

        if (load) begin
            en_d  = en_in;
            dvd_d = dvd_in;
            div_d = div_in;
            rem_d = '0;
            quo_d = '0;
        end else if (step) begin
            dvd_d = dvd_q << 1;
            rem_d = rem_nxt;
            quo_d = quo_nxt;
            if (last && en_q) begin
                if (div_q != '0) begin
                    q_d  = quo_nxt;
                    dz_d = 1'b0;
                end else begin
                    dz_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            en_q  <= 1'b0;
            dvd_q <= '0;
            div_q <= '0;
            rem_q <= '0;
            quo_q <= '0;
            q_q   <= '0;
            dz_q  <= 1'b0;
        end else begin
            en_q  <= en_d;
            dvd_q <= dvd_d;
            div_q <= div_d;
            rem_q <= rem_d;
            quo_q <= quo_d;
            q_q   <= q_d;
            dz_q  <= dz_d;
        end
    end

    assign q  = q_q;
    assign dz = dz_q;
endmodule

module centroid_divider #(
    parameter int CH    = 16,
    parameter int NUM_W = 20,
    parameter int DEN_W = 12
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [CH-1:0]       en,
    input  logic [CH*NUM_W-1:0] dividend,
    input  logic [CH*DEN_W-1:0] divisor,
    output logic                busy,
    output logic                done,
    output logic                all_ready,
    output logic [CH-1:0]       dz,
    output logic [CH*NUM_W-1:0] q
);
    localparam int CNT_W = $clog2(NUM_W + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_W - 1);

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             all_ready_q, all_ready_d;
    logic             load, step, last;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        all_ready_d = all_ready_q;
        load        = 1'b0;
        step        = 1'b0;
        last        = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    load        = 1'b1;
                    cnt_d       = '0;
                    all_ready_d = 1'b0;
                    state_d     = RUN;
                end
            end
            RUN: begin
                step  = 1'b1;
                cnt_d = cnt_q + 1'b1;
                // Final step writes results so they appear together with done.
                if (cnt_q == LAST_CNT) begin
                    last        = 1'b1;
                    cnt_d       = '0;
                    all_ready_d = 1'b1;
                    state_d     = FIN;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            all_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            all_ready_q <= all_ready_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = (state_q == FIN);
    assign all_ready = all_ready_q;

    for (genvar i = 0; i < CH; i++) begin : g_lane
        centroid_divider_lane #(.NUM_W(NUM_W), .DEN_W(DEN_W)) u_lane (
            .clk    (clk),
            .reset  (reset),
            .load   (load),
            .step   (step),
            .last   (last),
            .en_in  (en[i]),
            .dvd_in (dividend[i*NUM_W +: NUM_W]),
            .div_in (divisor[i*DEN_W +: DEN_W]),
            .q      (q[i*NUM_W +: NUM_W]),
            .dz     (dz[i])
        );
    end
endmodule

// File: tb/tb_centroid_divider.sv
// Self-checking bench for centroid_divider: directed scenarios plus randomized back-to-back
// operations compared against a per-channel floor-division model.

module tb_centroid_divider;
    localparam int CH    = 16;
    localparam int NUM_W = 20;
    localparam int DEN_W = 12;

    logic                clk = 1'b0;
    logic                reset, start;
    logic [CH-1:0]       en;
    logic [CH*NUM_W-1:0] dividend;
    logic [CH*DEN_W-1:0] divisor;
    logic                busy, done, all_ready;
    logic [CH-1:0]       dz;
    logic [CH*NUM_W-1:0] q;

    centroid_divider #(.CH(CH), .NUM_W(NUM_W), .DEN_W(DEN_W)) dut (
        .clk(clk), .reset(reset), .start(start), .en(en), .dividend(dividend),
        .divisor(divisor), .busy(busy), .done(done), .all_ready(all_ready), .dz(dz), .q(q)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Reference state and pending operands
    logic [NUM_W-1:0] m_q [CH];
    logic [CH-1:0]    m_dz;
    logic [NUM_W-1:0] op_dvd [CH];
    logic [DEN_W-1:0] op_div [CH];
    logic [CH-1:0]    op_en;

    function automatic logic [CH*NUM_W-1:0] exp_q_vec();
        logic [CH*NUM_W-1:0] v;
        for (int i = 0; i < CH; i++) v[i*NUM_W +: NUM_W] = m_q[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < CH; i++) m_q[i] = '0;
        m_dz = '0;
    endtask

    task automatic model_accept();
        for (int i = 0; i < CH; i++) begin
            if (op_en[i]) begin
                if (op_div[i] != '0) begin
                    m_q[i]  = op_dvd[i] / op_div[i];
                    m_dz[i] = 1'b0;
                end else begin
                    m_dz[i] = 1'b1;
                end
            end
        end
    endtask

    task automatic randomize_ops();
        for (int i = 0; i < CH; i++) begin
            op_dvd[i] = NUM_W'($urandom);
            case ($urandom_range(0, 7))
                0:       op_div[i] = '0;
                1, 2:    op_div[i] = DEN_W'($urandom_range(1, 15));
                default: op_div[i] = DEN_W'($urandom);
            endcase
        end
        op_en = CH'($urandom);
    endtask

    task automatic load_inputs();
        for (int i = 0; i < CH; i++) begin
            dividend[i*NUM_W +: NUM_W] = op_dvd[i];
            divisor[i*DEN_W +: DEN_W]  = op_div[i];
        end
        en = op_en;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input bit apply_model);
        load_inputs();
        start = 1'b1;
        tick();
        start = 1'b0;
        if (apply_model) model_accept();
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (done !== 1'b1 && cyc < 200) begin
            tick();
            cyc++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; en = '0; dividend = '0; divisor = '0;
        tick(); tick();
        reset = 1'b0;
        model_reset();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (all_ready !== 1'b0) begin errors++; $display("FAIL reset_all_ready got %b want 0", all_ready); end
        checks++; if (dz !== '0) begin errors++; $display("FAIL reset_dz got %h want 0", dz); end
        checks++; if (q !== '0) begin errors++; $display("FAIL reset_q got %h want 0", q); end
    endtask

    task automatic test_basic();
        int cyc;
        for (int i = 0; i < CH; i++) begin op_dvd[i] = NUM_W'($urandom); op_div[i] = DEN_W'($urandom); end
        op_dvd[0] = 20'd1000; op_div[0] = 12'd7; op_en = 16'h0001;
        start_op(1'b1);
        checks++; if (busy !== 1'b1 || all_ready !== 1'b0)
            begin errors++; $display("FAIL basic_running busy=%b all_ready=%b want 1/0", busy, all_ready); end
        wait_done(cyc);
        checks++; if (cyc != NUM_W) begin errors++; $display("FAIL basic_latency got %0d want %0d", cyc, NUM_W); end
        checks++; if (q[NUM_W-1:0] !== 20'd142) begin errors++; $display("FAIL basic_q0 got %0d want 142", q[NUM_W-1:0]); end
        checks++; if (q !== exp_q_vec()) begin errors++; $display("FAIL basic_q got %h want %h", q, exp_q_vec()); end
        checks++; if (dz !== m_dz) begin errors++; $display("FAIL basic_dz got %h want %h", dz, m_dz); end
        checks++; if (all_ready !== 1'b1 || busy !== 1'b1)
            begin errors++; $display("FAIL basic_fin all_ready=%b busy=%b want 1/1", all_ready, busy); end
        tick();
        checks++; if (done !== 1'b0 || busy !== 1'b0 || all_ready !== 1'b1)
            begin errors++; $display("FAIL basic_idle done=%b busy=%b all_ready=%b want 0/0/1", done, busy, all_ready); end
    endtask

    task automatic test_max();
        int cyc;
        for (int i = 0; i < CH; i++) begin
            op_dvd[i] = 20'hFFFFF;
            op_div[i] = DEN_W'($urandom_range(1, 4095));
        end
        op_div[0] = 12'd1; op_div[15] = 12'hFFF; op_en = '1;
        start_op(1'b1);
        wait_done(cyc);
        checks++; if (cyc != NUM_W) begin errors++; $display("FAIL max_latency got %0d want %0d", cyc, NUM_W); end
        checks++; if (q[NUM_W-1:0] !== 20'hFFFFF) begin errors++; $display("FAIL max_q0 got %h want fffff", q[NUM_W-1:0]); end
        checks++; if (q[15*NUM_W +: NUM_W] !== 20'h00100)
            begin errors++; $display("FAIL max_q15 got %h want 00100", q[15*NUM_W +: NUM_W]); end
        checks++; if (q !== exp_q_vec()) begin errors++; $display("FAIL max_q got %h want %h", q, exp_q_vec()); end
        checks++; if (dz !== '0) begin errors++; $display("FAIL max_dz got %h want 0", dz); end
        tick();
    endtask

    task automatic test_dz_mask();
        int cyc;
        randomize_ops();
        op_dvd[3] = 20'd55; op_div[3] = 12'd1;
        op_dvd[4] = 20'd90; op_div[4] = 12'd9;
        op_en = 16'h0018;
        start_op(1'b1);
        wait_done(cyc);
        checks++; if (q[3*NUM_W +: NUM_W] !== 20'd55) begin errors++; $display("FAIL dz_setup_q3 got %0d want 55", q[3*NUM_W +: NUM_W]); end
        tick();
        randomize_ops();
        op_div[3] = '0; op_div[4] = 12'd3; op_dvd[4] = 20'd999;
        op_en = 16'h0008;
        start_op(1'b1);
        wait_done(cyc);
        checks++; if (q[3*NUM_W +: NUM_W] !== 20'd55) begin errors++; $display("FAIL dz_q3_hold got %0d want 55", q[3*NUM_W +: NUM_W]); end
        checks++; if (dz[3] !== 1'b1) begin errors++; $display("FAIL dz_flag3 got %b want 1", dz[3]); end
        checks++; if (q[4*NUM_W +: NUM_W] !== 20'd10) begin errors++; $display("FAIL dz_q4_masked got %0d want 10", q[4*NUM_W +: NUM_W]); end
        checks++; if (q !== exp_q_vec() || dz !== m_dz)
            begin errors++; $display("FAIL dz_all q=%h dz=%h want q=%h dz=%h", q, dz, exp_q_vec(), m_dz); end
        tick();
    endtask

    task automatic test_start_while_busy();
        int cyc, pulses;
        randomize_ops(); op_en = '1;
        start_op(1'b1);
        repeat (4) tick();
        randomize_ops(); op_en = '1;
        load_inputs();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(cyc);
        checks++; if (cyc + 5 != NUM_W) begin errors++; $display("FAIL busy_start_latency got %0d want %0d", cyc + 5, NUM_W); end
        checks++; if (q !== exp_q_vec() || dz !== m_dz)
            begin errors++; $display("FAIL busy_start_result q=%h dz=%h want q=%h dz=%h", q, dz, exp_q_vec(), m_dz); end
        pulses = 0;
        repeat (NUM_W + 4) begin tick(); if (done === 1'b1) pulses++; end
        checks++; if (pulses != 0) begin errors++; $display("FAIL busy_start_extra_done got %0d want 0", pulses); end
    endtask

    task automatic test_reset_mid();
        int pulses;
        randomize_ops(); op_en = '1;
        start_op(1'b0);
        repeat (9) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_reset();
        checks++; if (busy !== 1'b0 || done !== 1'b0 || all_ready !== 1'b0)
            begin errors++; $display("FAIL rst_mid_ctrl busy=%b done=%b all_ready=%b want 0/0/0", busy, done, all_ready); end
        checks++; if (q !== '0 || dz !== '0) begin errors++; $display("FAIL rst_mid_data q=%h dz=%h want 0/0", q, dz); end
        pulses = 0;
        repeat (NUM_W + 4) begin tick(); if (done === 1'b1) pulses++; end
        checks++; if (pulses != 0) begin errors++; $display("FAIL rst_mid_done got %0d pulses want 0", pulses); end
    endtask

    task automatic test_all_disabled();
        int cyc;
        randomize_ops(); op_en = '1;
        start_op(1'b1);
        wait_done(cyc);
        tick();
        randomize_ops(); op_en = '0;
        start_op(1'b1);
        wait_done(cyc);
        checks++; if (cyc != NUM_W) begin errors++; $display("FAIL dis_latency got %0d want %0d", cyc, NUM_W); end
        checks++; if (q !== exp_q_vec() || dz !== m_dz)
            begin errors++; $display("FAIL dis_hold q=%h dz=%h want q=%h dz=%h", q, dz, exp_q_vec(), m_dz); end
        tick();
    endtask

    task automatic test_back_to_back();
        int cyc, last_done, period;
        randomize_ops();
        start_op(1'b1);
        last_done = 0;
        for (int it = 0; it < 8; it++) begin
            wait_done(cyc);
            checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_timeout op %0d got done=%b want 1", it, done); end
            if (it > 0) begin
                period = cyc_cnt - last_done;
                checks++; if (period != NUM_W + 2) begin errors++; $display("FAIL b2b_period op %0d got %0d want %0d", it, period, NUM_W + 2); end
            end
            last_done = cyc_cnt;
            checks++; if (q !== exp_q_vec() || dz !== m_dz)
                begin errors++; $display("FAIL b2b_result op %0d q=%h dz=%h want q=%h dz=%h", it, q, dz, exp_q_vec(), m_dz); end
            if (it < 7) begin
                randomize_ops();
                load_inputs();
                start = 1'b1;
                tick();
                checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_fin_start op %0d busy=%b want 0", it, busy); end
                tick();
                start = 1'b0;
                model_accept();
                randomize_ops();
                load_inputs();
            end
        end
        tick();
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; en = '0; dividend = '0; divisor = '0;
        test_reset();
        test_basic();
        test_max();
        test_dz_mask();
        test_start_while_busy();
        test_reset_mid();
        test_all_disabled();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
